muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and HI/LO width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request an operation; sampled only when accept (REQ-012) is true.
REQ-005 op  input  3  000 NOP, 001 MUL, 010 MULU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
REQ-006 rs  input  DATA_WIDTH  multiplicand, dividend, or MTHI/MTLO data.
REQ-007 rt  input  DATA_WIDTH  multiplier or divisor.
REQ-008 flush  input  1  abort the in-flight operation.
REQ-009 hi, lo  output  DATA_WIDTH each  architectural HI/LO registers; these feed the ALU MFHI/MFLO path.
REQ-010 busy  output  1  high while state is RUN; the pipeline uses it as a stall request.
REQ-011 done  output  1  one-cycle pulse, high while state is DONE.

Function
REQ-012 States are IDLE, RUN and DONE. accept = start & (state is IDLE or DONE) & ~flush.
REQ-013 Accepted MUL/MULU/DIV/DIVU:
- operands are latched;
- the 6-bit iteration counter is cleared;
- next state is RUN.
REQ-014 Accepted MTHI/MTLO:
- the selected register takes rs at that edge;
- next state is IDLE;
- done is not pulsed.
REQ-015 Accepted NOP: next state is IDLE; it has no other effect.
REQ-016 RUN performs one iteration per cycle:
- MUL/MULU use shift-add;
- DIV/DIVU use restoring division on operand magnitudes.
REQ-017 After DATA_WIDTH iterations, the unit does the following at the same edge:
- writes hi/lo;
- moves to DONE.
Latency from the accept edge to done high is DATA_WIDTH+1 edges. busy is high for exactly DATA_WIDTH cycles.
REQ-018 DONE lasts one cycle. Next state is IDLE, or the new state per REQ-013/014 if a start is accepted in DONE.
REQ-019 Product results:
- {hi,lo} = full 2*DATA_WIDTH-bit product;
- MUL treats both operands as signed;
- MULU treats both operands as unsigned.
REQ-020 Division results:
- lo = quotient, truncated toward zero;
- hi = remainder, which carries the sign of rs (DIV);
- DIVU is fully unsigned.
REQ-021 Divide by zero has a deterministic result:
- DIVU: lo = all ones, hi = rs;
- DIV with rs >= 0: lo = all ones, hi = rs;
- DIV with rs < 0: lo = 1, hi = rs.
REQ-022 DIV of the most negative value by -1 gives lo = most negative value and hi = 0.
REQ-023 start while RUN is ignored. It does not alter the operands, the counter or the result.
REQ-024 flush in RUN or DONE has this effect at that edge:
- next state is IDLE;
- hi/lo are not written.
A start in the same cycle is dropped. flush in IDLE has no effect.
REQ-025 hi/lo hold their value in every cycle not named in REQ-014/017.
REQ-026 Operand inputs may change freely after the accept edge without affecting the result.

Reset
REQ-027 When rst is high at an edge, the unit does the following, overriding start and flush:
- state becomes IDLE;
- hi = 0 and lo = 0;
- busy = 0 and done = 0;
- the counter and operand registers are cleared.
REQ-028 Reset during RUN discards the operation, and no hi/lo write occurs.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN.
- Defined: an accepted MUL/MULU computes the product with a single-cycle multiplier. The unit writes hi/lo at the accept edge and goes directly to DONE; busy is never asserted for multiplies. DIV/DIVU are unchanged.
- Undefined: multiplies are iterative per REQ-016/017.

Verification
REQ-030 MULU, rs=0xFFFFFFFF, rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE. done is at accept+33 edges, or accept+1 with MULDIV_FAST_MUL_EN.
REQ-031 MUL, rs=0xFFFFFFFD (-3), rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-032 Division cases:
- DIV, rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
- DIVU, rs=0x80000000, rt=0 -> lo=0xFFFFFFFF, hi=0x80000000.
REQ-033 DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start DIVU 100/7, pulse flush at RUN cycle 10 -> IDLE next edge, no done, hi/lo keep their prior values. Then MTLO 0x1234 -> lo=0x1234 one edge later, with busy low throughout.
REQ-035 Back-to-back and reset cases:
- start MULU in the DONE cycle of a prior DIVU -> the second result is correct, and done pulses twice with 32 busy cycles between;
- rst asserted mid-RUN -> hi=lo=0, IDLE.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] rs;
    logic [DATA_WIDTH-1:0] rt;
    logic                  flush;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  busy;
    logic                  done;

    modport master (output start, op, rs, rt, flush, input hi, lo, busy, done);
    modport slave  (input start, op, rs, rt, flush, output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO unit: shift-add multiply and restoring divide on operand magnitudes.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_MULU = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b101;
    localparam logic [2:0] OP_MTLO = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic           div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;

    logic           accept, sgn, is_div;
    logic [W-1:0]   mag_rs, mag_rt, quo, rem;
    logic [W:0]     rem_sh, diff, sum;
    logic [2*W-1:0] prod;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_sh  = '0;
        diff    = '0;
        sum     = '0;
        prod    = '0;
        quo     = '0;
        rem     = '0;

        accept = bus.start & (state_q != RUN) & ~bus.flush;
        sgn    = (bus.op == OP_MUL) | (bus.op == OP_DIV);
        is_div = (bus.op == OP_DIV) | (bus.op == OP_DIVU);
        mag_rs = (sgn & bus.rs[W-1]) ? -bus.rs : bus.rs;
        mag_rt = (sgn & bus.rt[W-1]) ? -bus.rt : bus.rt;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{W{sgn & bus.rs[W-1]}}, bus.rs} * {{W{sgn & bus.rt[W-1]}}, bus.rt};
`endif

        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    // acc holds {remainder, dividend/quotient} for divide, {partial, multiplier} for multiply
                    if (div_q) begin
                        rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
                        diff   = rem_sh - {1'b0, a_q};
                        if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
                        else          acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
                    end else begin
                        sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
                        acc_d = {sum, acc_q[W-1:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(W-1)) begin
                        state_d = DONE;
                        if (div_q) begin
                            quo  = acc_d[W-1:0];
                            rem  = acc_d[2*W-1:W];
                            lo_d = neg_q ? -quo : quo;
                            hi_d = rneg_q ? -rem : rem;
                        end else begin
                            prod         = neg_q ? -acc_d : acc_d;
                            {hi_d, lo_d} = prod;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            state_d = IDLE;
            case (bus.op)
                OP_MUL, OP_MULU, OP_DIV, OP_DIVU: begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        {hi_d, lo_d} = fast_prod;
                        state_d      = DONE;
                    end else
`endif
                    begin
                        // signed divide-by-zero and MIN/-1 fall out of the magnitude/sign fixup
                        cnt_d   = '0;
                        div_d   = is_div;
                        neg_d   = sgn & (bus.rs[W-1] ^ bus.rt[W-1]);
                        rneg_d  = sgn & bus.rs[W-1];
                        a_d     = is_div ? mag_rt : mag_rs;
                        acc_d   = {{W{1'b0}}, (is_div ? mag_rs : mag_rt)};
                        state_d = RUN;
                    end
                end
                OP_MTHI: hi_d = bus.rs;
                OP_MTLO: lo_d = bus.rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.DATA_WIDTH(W)) bus ();
    muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        int           blen;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain arithmetic on the architectural rules
    task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb2;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb2); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: begin
                if (b == 0) begin m_lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = 32'(sa / sb2); m_hi = 32'(sa % sb2); end
            end
            3'd4: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic wait_free();
        int n = 0;
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("wait_free_timeout", 1, 0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        wait_free();
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
        ref_op(op, a, b);
        if (op >= 3'd1 && op <= 3'd4) begin
            lat = W;
`ifdef MULDIV_FAST_MUL_EN
            if (op <= 3'd2) lat = 0;
`endif
            e.hi = m_hi; e.lo = m_lo; e.cyc = cyc + 1 + lat; e.blen = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.rs = $urandom; bus.rt = $urandom;
        if (op == 3'd5 || op == 3'd6) begin
            check("mt_hi", bus.hi, m_hi);
            check("mt_lo", bus.lo, m_lo);
            check("mt_busy", bus.busy, 0);
            check("mt_done", bus.done, 0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   run = 0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sb.size() == 0) check("spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("res_hi", bus.hi, e.hi);
                    check("res_lo", bus.lo, e.lo);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_len", run, e.blen);
                end
                run = 0;
            end else if (bus.busy) run++;
            else run = 0;
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);

        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(3'd1, 32'hFFFF_FFFD, 32'h0000_0007);
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        issue(3'd4, 32'h8000_0000, 32'h0000_0000);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFF0, 32'h0000_0000);
        // second op lands in the DONE cycle of the first
        issue(3'd4, 32'd1000, 32'd33);
        issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);

        // start while RUN must be ignored
        issue(3'd3, 32'd12345, 32'hFFFF_FFF5);
        bus.start = 1'b1; bus.op = 3'd5; bus.rs = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;

        // flush at RUN cycle 10
        wait_free();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.rs = 32'd100; bus.rt = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_pre_busy", bus.busy, 1);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_hi", bus.hi, m_hi);
        check("flush_lo", bus.lo, m_lo);
        repeat (40) @(negedge clk);
        issue(3'd6, 32'h0000_1234, 32'd0);

        // reset mid-RUN
        wait_free();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.rs = 32'd999; bus.rt = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 60; i++) issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());

        n = 0;
        while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
